tdm_demux: RTL and testbench

Time-division demultiplexer: the receive end of a serial TDM link whose transmit side selects one channel at a time through the team's multiplexer cells. Recovers CHANNELS parallel words of WIDTH bits from a single serial bit stream framed by a sync strobe. Presents a whole frame atomically with a one-cycle valid pulse. Detects and reports framing errors. Sits between the serial link input and the per-channel consumers.

---
 rtl/tdm_demux_pkg.sv | 18 +
 rtl/tdm_demux_ch_decoder.sv | 27 ++
 rtl/tdm_demux.sv | 162 ++++++++++++++++
 tb/tb_tdm_demux.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// rtl/tdm_demux_pkg.sv - shared state encodings and default geometry for the TDM link
//
// Contents:
//   tdm_state_t   receiver FSM state (TDM_HUNT, TDM_RECV)
//   TDM_CHANNELS  default slots per frame, shared with the transmitter
//   TDM_WIDTH     default bits per slot, shared with the transmitter

package tdm_demux_pkg;

   typedef enum logic {
      TDM_HUNT = 1'b0,
      TDM_RECV = 1'b1
   } tdm_state_t;

   localparam int TDM_CHANNELS = 4;
   localparam int TDM_WIDTH    = 8;

endpackage

// File: rtl/tdm_demux_ch_decoder.sv
// rtl/tdm_demux_ch_decoder.sv - one-hot slot decoder producing per-channel shift enables
//
// Ports:
//   din_valid  serial bit qualifier
//   accept     the current bit is to be stored (not discarded)
//   sel        slot the current bit belongs to
//   shift_en   one-hot shift enable per channel, all zero unless din_valid and accept

module tdm_demux_ch_decoder #(
   parameter int CHANNELS = 4
) (
   input  logic                        din_valid,
   input  logic                        accept,
   input  logic [$clog2(CHANNELS)-1:0] sel,
   output logic [CHANNELS-1:0]         shift_en
);

   localparam int CW = $clog2(CHANNELS);

   always_comb begin
      shift_en = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         shift_en[c] = din_valid && accept && (sel == CW'(c));
      end
   end

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - serial TDM receiver: recovers CHANNELS words per sync-framed frame
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   din         serial data bit, sampled when din_valid=1
//   din_valid   input qualifier
//   frame       marks the first bit of a frame
//   data_out    last complete frame, channel c in bits [c*WIDTH +: WIDTH]
//   out_valid   one-cycle pulse when data_out updates
//   ch_sel      slot the next accepted bit belongs to
//   sync_err    one-cycle pulse on a framing error

module tdm_demux
   import tdm_demux_pkg::*;
#(
   parameter int CHANNELS = TDM_CHANNELS,
   parameter int WIDTH    = TDM_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        din,
   input  logic                        din_valid,
   input  logic                        frame,
   output logic [CHANNELS*WIDTH-1:0]   data_out,
   output logic                        out_valid,
   output logic [$clog2(CHANNELS)-1:0] ch_sel,
   output logic                        sync_err
);

   localparam int CW = $clog2(CHANNELS);
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);

   tdm_state_t state, state_nxt;

   logic [BW-1:0]                     bit_cnt, bit_cnt_nxt;
   logic [CW-1:0]                     ch_cnt, ch_cnt_nxt;
   logic [CHANNELS-1:0][WIDTH-1:0]    sr, sr_nxt;
   logic [CHANNELS-1:0]               shift_en;

   logic          at_start;
   logic          at_last;
   logic          start_bit;
   logic          take_bit;
   logic          err_nxt;
   logic          load_out;
   logic [CW-1:0] slot;
   logic [BW-1:0] cur_bit;
   logic [CW-1:0] cur_ch;

   assign ch_sel = ch_cnt;

   // In RECV, counters at zero only happen right after a completed frame
   // (a started frame always leaves them advanced), so this marks a frame boundary.
   assign at_start = (bit_cnt == '0) && (ch_cnt == '0);
   assign at_last  = (bit_cnt == BIT_LAST) && (ch_cnt == CH_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= TDM_HUNT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (din_valid) begin
         case (state)
            TDM_HUNT: if (frame) state_nxt = TDM_RECV;
            TDM_RECV: if (!frame && at_start) state_nxt = TDM_HUNT;
            default:  state_nxt = TDM_HUNT;
         endcase
      end
   end

   // Output / datapath control
   always_comb begin
      start_bit = 1'b0;
      take_bit  = 1'b0;
      err_nxt   = 1'b0;
      if (din_valid) begin
         case (state)
            TDM_HUNT: begin
               start_bit = frame;
            end
            TDM_RECV: begin
               if (frame) begin
                  // frame bit either opens the expected next frame or resyncs mid-frame
                  start_bit = 1'b1;
                  err_nxt   = !at_start;
               end else if (at_start) begin
                  err_nxt = 1'b1;
               end else begin
                  take_bit = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign load_out = take_bit && at_last;
   assign slot     = start_bit ? '0 : ch_cnt;

   tdm_demux_ch_decoder #(
      .CHANNELS (CHANNELS)
   ) u_ch_decoder (
      .din_valid (din_valid),
      .accept    (start_bit || take_bit),
      .sel       (slot),
      .shift_en  (shift_en)
   );

   // Counter advance; a start bit counts from position zero so resync
   // and a normal frame start share the same path.
   always_comb begin
      cur_bit     = start_bit ? '0 : bit_cnt;
      cur_ch      = start_bit ? '0 : ch_cnt;
      bit_cnt_nxt = bit_cnt;
      ch_cnt_nxt  = ch_cnt;
      if (start_bit || take_bit) begin
         if (cur_bit == BIT_LAST) begin
            bit_cnt_nxt = '0;
            ch_cnt_nxt  = (cur_ch == CH_LAST) ? '0 : cur_ch + 1'b1;
         end else begin
            bit_cnt_nxt = cur_bit + 1'b1;
            ch_cnt_nxt  = cur_ch;
         end
      end
   end

   always_comb begin
      sr_nxt = sr;
      for (int c = 0; c < CHANNELS; c++) begin
         if (shift_en[c]) sr_nxt[c] = WIDTH'({sr[c], din});
      end
   end

   // Datapath registers; data_out takes the shift registers including the final bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= '0;
         ch_cnt    <= '0;
         sr        <= '0;
         data_out  <= '0;
         out_valid <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         bit_cnt   <= bit_cnt_nxt;
         ch_cnt    <= ch_cnt_nxt;
         sr        <= sr_nxt;
         out_valid <= load_out;
         sync_err  <= err_nxt;
         if (load_out) data_out <= sr_nxt;
      end
   end

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - directed table-driven bench for tdm_demux

module tb_tdm_demux;

   logic        clk;
   logic        rst_n;
   logic        din;
   logic        din_valid;
   logic        frame;
   logic [31:0] data_out;
   logic        out_valid;
   logic [1:0]  ch_sel;
   logic        sync_err;

   int checks = 0;
   int errors = 0;

   tdm_demux #(
      .CHANNELS (4),
      .WIDTH    (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .din_valid (din_valid),
      .frame     (frame),
      .data_out  (data_out),
      .out_valid (out_valid),
      .ch_sel    (ch_sel),
      .sync_err  (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  c0;
      logic [7:0]  c1;
      logic [7:0]  c2;
      logic [7:0]  c3;
      logic [3:0]  gap;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic cw_bit(input logic [31:0] cw, input int i);
      return cw[(i / 8) * 8 + 7 - (i % 8)];
   endfunction

   task automatic bit_cycle(input logic b, input logic f, input logic v);
      din       = b;
      frame     = f;
      din_valid = v;
      @(posedge clk);
      #1;
   endtask

   // Sends bits lo..hi of a frame whose channel c byte is cw[c*8 +: 8];
   // frame is raised on bit lo when f_on_lo is set.
   task automatic send_range(input logic [31:0] cw, input int lo, input int hi,
                             input logic f_on_lo, output int ov_cnt, output int er_cnt);
      ov_cnt = 0;
      er_cnt = 0;
      for (int i = lo; i <= hi; i++) begin
         bit_cycle(cw_bit(cw, i), f_on_lo && (i == lo), 1'b1);
         if (out_valid === 1'b1) ov_cnt++;
         if (sync_err === 1'b1) er_cnt++;
      end
   endtask

   task automatic send_frame(input vec_t v, input logic [31:0] prev, input int idx);
      logic [31:0] cw;
      logic [31:0] mid;
      logic [1:0]  hold;
      int          g, cyc, bad_ov, bad_er, bad_ch, bad_gap;
      cw  = {v.c3, v.c2, v.c1, v.c0};
      g   = int'(v.gap);
      cyc = 0;
      bad_ov = 0; bad_er = 0; bad_ch = 0; bad_gap = 0;
      mid = '0;
      for (int i = 0; i < 32; i++) begin
         if (g != 0 && (cyc % g) == g - 1) begin
            hold = ch_sel;
            bit_cycle(1'($urandom_range(1)), 1'b1, 1'b0);
            cyc++;
            if (ch_sel !== hold || out_valid !== 1'b0 || sync_err !== 1'b0) bad_gap++;
         end
         if (ch_sel !== 2'(i / 8)) bad_ch++;
         bit_cycle(cw_bit(cw, i), i == 0, 1'b1);
         cyc++;
         if (out_valid !== (i == 31)) bad_ov++;
         if (sync_err !== 1'b0) bad_er++;
         if (i == 15) mid = data_out;
      end
      check($sformatf("vec%0d_out_valid_timing", idx), bad_ov, 0);
      check($sformatf("vec%0d_no_sync_err", idx), bad_er, 0);
      check($sformatf("vec%0d_ch_sel_track", idx), bad_ch, 0);
      if (g != 0) check($sformatf("vec%0d_gap_frozen", idx), bad_gap, 0);
      check($sformatf("vec%0d_data_out_mid", idx), mid, prev);
      check($sformatf("vec%0d_data_out", idx), data_out, v.exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] prev;
      int ov, er;

      vecs[0] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 4'd0, 32'hF00F3CA5};
      vecs[1] = '{8'h01, 8'h02, 8'h03, 8'h04, 4'd0, 32'h04030201};
      vecs[2] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 4'd3, 32'hF00F3CA5};
      vecs[3] = '{8'hFF, 8'h00, 8'h80, 8'h01, 4'd0, 32'h018000FF};
      vecs[4] = '{8'h12, 8'h34, 8'h56, 8'h78, 4'd2, 32'h78563412};

      // Reset, with activity on the inputs that must be ignored
      rst_n = 1'b0; din = 1'b1; frame = 1'b1; din_valid = 1'b1;
      #22;
      check("reset_data_out", data_out, 32'h0);
      check("reset_out_valid", 32'(out_valid), 0);
      check("reset_ch_sel", 32'(ch_sel), 0);
      check("reset_sync_err", 32'(sync_err), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // HUNT discards bits without frame
      ov = 0; er = 0;
      for (int i = 0; i < 5; i++) begin
         bit_cycle(1'($urandom_range(1)), 1'b0, 1'b1);
         if (out_valid === 1'b1) ov++;
         if (sync_err === 1'b1) er++;
      end
      check("hunt_idle_out_valid", ov, 0);
      check("hunt_idle_sync_err", er, 0);
      check("hunt_idle_ch_sel", 32'(ch_sel), 0);

      // Table: first from HUNT, then back-to-back frames, some with idle gaps
      prev = 32'h0;
      for (int k = 0; k < 5; k++) begin
         send_frame(vecs[k], prev, k);
         prev = vecs[k].exp;
      end

      // Resync: frame raised on bit 13 of a partial frame
      send_range(32'h00EEFFC0, 0, 12, 1'b1, ov, er);
      check("resync_prefix_out_valid", ov, 0);
      check("resync_prefix_sync_err", er, 0);
      bit_cycle(cw_bit(32'h44332211, 0), 1'b1, 1'b1);
      check("resync_sync_err", 32'(sync_err), 1);
      check("resync_out_valid", 32'(out_valid), 0);
      check("resync_data_out_held", data_out, 32'h78563412);
      send_range(32'h44332211, 1, 30, 1'b0, ov, er);
      check("resync_body_sync_err", er, 0);
      check("resync_body_out_valid", ov, 0);
      send_range(32'h44332211, 31, 31, 1'b0, ov, er);
      check("resync_done_out_valid", ov, 1);
      check("resync_data_out", data_out, 32'h44332211);

      // Missing frame bit after a completed frame: error, then HUNT
      bit_cycle(1'b1, 1'b0, 1'b1);
      check("noframe_sync_err", 32'(sync_err), 1);
      check("noframe_out_valid", 32'(out_valid), 0);
      ov = 0; er = 0;
      for (int i = 0; i < 40; i++) begin
         bit_cycle(1'($urandom_range(1)), 1'b0, 1'b1);
         if (out_valid === 1'b1) ov++;
         if (sync_err === 1'b1) er++;
      end
      check("hunt_ignore_out_valid", ov, 0);
      check("hunt_ignore_sync_err", er, 0);
      check("hunt_ignore_ch_sel", 32'(ch_sel), 0);
      check("hunt_ignore_data_out", data_out, 32'h44332211);
      send_range(32'hEFBEADDE, 0, 31, 1'b1, ov, er);
      check("rehunt_out_valid", ov, 1);
      check("rehunt_sync_err", er, 0);
      check("rehunt_data_out", data_out, 32'hEFBEADDE);

      // Reset pulsed at bit 20 of a frame
      send_range(32'h76543210, 0, 19, 1'b1, ov, er);
      check("prereset_ch_sel", 32'(ch_sel), 2);
      check("prereset_flags", ov + er, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_data_out", data_out, 32'h0);
      check("midreset_out_valid", 32'(out_valid), 0);
      check("midreset_ch_sel", 32'(ch_sel), 0);
      check("midreset_sync_err", 32'(sync_err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      ov = 0; er = 0;
      for (int i = 0; i < 3; i++) begin
         bit_cycle(1'b1, 1'b0, 1'b1);
         if (out_valid === 1'b1) ov++;
         if (sync_err === 1'b1) er++;
      end
      check("postreset_hunt_flags", ov + er, 0);
      send_range(32'h0FF0C35A, 0, 31, 1'b1, ov, er);
      check("postreset_out_valid", ov, 1);
      check("postreset_sync_err", er, 0);
      check("postreset_data_out", data_out, 32'h0FF0C35A);
      bit_cycle(1'b0, 1'b0, 1'b0);
      check("postreset_pulse_end", 32'(out_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
